// File: rtl/spi_prog_sequencer.sv
// spi_prog_sequencer: serialises address/data words into SPI program bytes; SPI_PROG_ADDR_SKIP_EN drops the address phase for in-step words
module spi_prog_sequencer #(
  parameter int ADDR_BYTES = 4,
  parameter int DATA_BYTES = 4,
  parameter logic [7:0] OP_ADDR = 8'h01,
  parameter logic [7:0] OP_DATA = 8'h02,
  parameter int ADDR_STEP = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [8*ADDR_BYTES-1:0] base_addr,
  input  logic                    addr_load,
  input  logic [8*DATA_BYTES-1:0] word_data,
  input  logic                    word_valid,
  output logic                    word_ready,
  output logic                    spi_start,
  output logic [7:0]              spi_data,
  input  logic                    spi_done,
  output logic                    busy,
  output logic [CNT_W-1:0]        words_sent,
  output logic [8*ADDR_BYTES-1:0] cur_addr,
  output logic                    timeout_err
);
  localparam int AW = 8*ADDR_BYTES;
  localparam int DW = 8*DATA_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [3:0] LAST = 4'(1+ADDR_BYTES+DATA_BYTES);
  localparam logic [3:0] DSTART = 4'(ADDR_BYTES+1);
  if (ADDR_BYTES < 1 || ADDR_BYTES > 4 || DATA_BYTES < 1 || DATA_BYTES > 4) begin : g_bad
    $error("spi_prog_sequencer: ADDR_BYTES and DATA_BYTES must be 1..4");
  end
  typedef enum logic [2:0] {
    IDLE,
`ifdef SPI_PROG_ADDR_SKIP_EN
    ACCEPT,
`endif
    ISSUE, WAIT, NEXT
  } state_t;
  state_t state, nstate;
  logic [3:0]    idx;
  logic [DW-1:0] wdata;
  logic [TW-1:0] wcnt;
  logic [AW-1:0] pend_addr;
  logic [7:0]    cur_byte;
  logic done_q, pend, up, rise, tmo, accept, skip;
  assign busy       = state != IDLE;
  assign word_ready = up && state == IDLE;
  assign spi_start  = state == ISSUE;
  assign spi_data   = spi_start ? cur_byte : 8'h00;
  assign rise       = spi_done && !done_q;
  assign accept     = word_valid && word_ready;
  assign tmo        = state == WAIT && !rise && wcnt == TW'(TIMEOUT_CYCLES-1);
`ifdef SPI_PROG_ADDR_SKIP_EN
  // in step: the slave's auto-incremented address already matches cur_addr
  logic in_step;
  assign skip = in_step && !pend && !addr_load;
  always_ff @(posedge clk)
    in_step <= (reset || tmo || (state == IDLE && (addr_load || pend))) ? 1'b0 : state == NEXT ? 1'b1 : in_step;
`else
  assign skip = 1'b0;
`endif
  always_comb begin
    nstate = state;
    case (state)
`ifdef SPI_PROG_ADDR_SKIP_EN
      IDLE:   nstate = accept ? (skip ? ACCEPT : ISSUE) : IDLE;
      ACCEPT: nstate = ISSUE;
`else
      IDLE:   nstate = accept ? ISSUE : IDLE;
`endif
      ISSUE:  nstate = WAIT;
      WAIT:   nstate = tmo ? IDLE : rise ? (idx == LAST ? NEXT : ISSUE) : WAIT;
      NEXT:   nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end
  always_comb begin
    cur_byte = idx == DSTART ? OP_DATA : OP_ADDR;
    for (int i = 0; i < ADDR_BYTES; i++)
      if (idx == 4'(i+1)) cur_byte = cur_addr[8*(ADDR_BYTES-1-i) +: 8];
    for (int i = 0; i < DATA_BYTES; i++)
      if (idx == 4'(ADDR_BYTES+2+i)) cur_byte = wdata[8*(DATA_BYTES-1-i) +: 8];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      wdata       <= '0;
      wcnt        <= '0;
      done_q      <= 1'b0;
      pend        <= 1'b0;
      pend_addr   <= '0;
      up          <= 1'b0;
      cur_addr    <= '0;
      words_sent  <= '0;
      timeout_err <= 1'b0;
    end else begin
      state  <= nstate;
      done_q <= spi_done;
      up     <= 1'b1;
      if (accept) begin
        wdata <= word_data;
        idx   <= skip ? DSTART : 4'd0;
      end
      if (state == ISSUE) wcnt <= '0;
      if (state == WAIT) begin
        wcnt <= wcnt + 1'b1;
        if (rise && idx != LAST) idx <= idx + 4'd1;
      end
      if (tmo) timeout_err <= 1'b1;
      if (state == NEXT) begin
        cur_addr   <= cur_addr + AW'(ADDR_STEP);
        words_sent <= words_sent + 1'b1;
      end
      if (addr_load) begin
        pend      <= 1'b1;
        pend_addr <= base_addr;
      end
      // a load seen while busy is replayed in IDLE, overriding any NEXT increment
      if (state == IDLE && (addr_load || pend)) begin
        cur_addr    <= addr_load ? base_addr : pend_addr;
        pend        <= 1'b0;
        timeout_err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_prog_sequencer.sv
// tb_spi_prog_sequencer: directed checks of the SPI program sequencer with a delayed spi_done responder
module tb_spi_prog_sequencer;
  localparam int T = 4096;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic [31:0] base_addr = 0, word_data = 0;
  logic addr_load = 0, word_valid = 0, en2 = 0, resp_en = 1;
  logic word_ready, spi_start, spi_done = 0, busy, timeout_err;
  logic [7:0] spi_data;
  logic [15:0] words_sent;
  logic [31:0] cur_addr;
  logic word_ready2, spi_start2, spi_done2 = 0, busy2, timeout_err2, word_valid2, addr_load2;
  logic [7:0] spi_data2;
  logic [15:0] words_sent2, cur_addr2;
  assign word_valid2 = word_valid && en2;
  assign addr_load2  = addr_load && en2;
  int pass_n = 0, total_n = 0, dcnt = 0, dcnt2 = 0;
  logic [7:0] q[$], q2[$];

  spi_prog_sequencer dut (
    .clk(clk), .reset(reset), .base_addr(base_addr), .addr_load(addr_load),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .spi_start(spi_start), .spi_data(spi_data), .spi_done(spi_done), .busy(busy),
    .words_sent(words_sent), .cur_addr(cur_addr), .timeout_err(timeout_err));

  spi_prog_sequencer #(.ADDR_BYTES(2)) dut2 (
    .clk(clk), .reset(reset), .base_addr(base_addr[15:0]), .addr_load(addr_load2),
    .word_data(word_data), .word_valid(word_valid2), .word_ready(word_ready2),
    .spi_start(spi_start2), .spi_data(spi_data2), .spi_done(spi_done2), .busy(busy2),
    .words_sent(words_sent2), .cur_addr(cur_addr2), .timeout_err(timeout_err2));

  always @(negedge clk) begin
    if (spi_start) begin q.push_back(spi_data); spi_done = 0; dcnt = 20; end
    else if (dcnt > 0) begin dcnt--; if (dcnt == 0) spi_done = resp_en; end
  end
  always @(negedge clk) begin
    if (spi_start2) begin q2.push_back(spi_data2); spi_done2 = 0; dcnt2 = 20; end
    else if (dcnt2 > 0) begin dcnt2--; if (dcnt2 == 0) spi_done2 = resp_en; end
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total_n++;
    assert (o === e) pass_n++;
    else $error("FAIL %s: got %0h expected %0h", tag, o, e);
  endtask

  task automatic send(input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    while (!word_ready && n < 3000) begin n++; @(negedge clk); end
    chk("ready_wait", word_ready, 1);
    word_data = d;
    word_valid = 1;
    @(negedge clk);
    word_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    logic rd = 0;
    @(negedge clk);
    while (busy && n < 3000) begin rd |= word_ready; n++; @(negedge clk); end
    chk("idle_wait", busy, 0);
    chk("ready_low_busy", rd, 0);
  endtask

  task automatic load(input logic [31:0] a);
    @(negedge clk);
    base_addr = a;
    addr_load = 1;
    @(negedge clk);
    addr_load = 0;
  endtask

  task automatic wait_starts(input int target, output int c);
    int n = 0;
    c = 1;
    while (c < target && n < 3000) begin @(negedge clk); n++; if (spi_start) c++; end
  endtask

  function automatic logic [31:0] qword(input int i);
    return {q[i], q[i+1], q[i+2], q[i+3]};
  endfunction

  initial begin
    logic [7:0] e1[10];
    logic [31:0] w3[3];
    int c;
    e1 = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    w3 = '{32'h13, 32'h93, 32'h113};
    repeat (3) @(negedge clk);
    chk("rst_word_ready", word_ready, 0);
    chk("rst_spi_start", spi_start, 0);
    chk("rst_spi_data", spi_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_words_sent", words_sent, 0);
    chk("rst_cur_addr", cur_addr, 0);
    chk("rst_timeout_err", timeout_err, 0);
    reset = 0;
    @(negedge clk);
    chk("ready_after_rst", word_ready, 1);

    load(32'h1000_0000);
    chk("load_addr", cur_addr, 32'h1000_0000);
    q.delete();
    send(32'hDEADBEEF);
    wait_idle();
    chk("w1_nbytes", q.size(), 10);
    for (int i = 0; i < 10; i++) chk($sformatf("w1_byte%0d", i), q[i], e1[i]);
    chk("w1_words_sent", words_sent, 1);
    chk("w1_cur_addr", cur_addr, 32'h1000_0004);

    load(32'h1000_0000);
    q.delete();
    for (int w = 0; w < 3; w++) begin send(w3[w]); wait_idle(); end
    chk("b2b_nbytes", q.size(), 30);
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("b2b_op_addr%0d", w), q[10*w], 8'h01);
      chk($sformatf("b2b_addr%0d", w), qword(10*w+1), 32'h1000_0000 + 32'(4*w));
      chk($sformatf("b2b_op_data%0d", w), q[10*w+5], 8'h02);
      chk($sformatf("b2b_data%0d", w), qword(10*w+6), w3[w]);
    end
    chk("b2b_words_sent", words_sent, 4);
    chk("b2b_cur_addr", cur_addr, 32'h1000_000C);

    resp_en = 0;
    q.delete();
    send(32'h0000_0055);
    @(posedge clk);
    repeat (T-1) @(posedge clk);
    #1;
    chk("tmo_not_early", timeout_err, 0);
    chk("tmo_busy_before", busy, 1);
    @(posedge clk);
    #1;
    chk("tmo_set", timeout_err, 1);
    chk("tmo_idle", busy, 0);
    chk("tmo_words_sent", words_sent, 4);
    chk("tmo_one_byte", q.size(), 1);
    resp_en = 1;
    load(32'h1000_0000);
    chk("tmo_cleared", timeout_err, 0);

    q.delete();
    send(32'hCAFEF00D);
    wait_starts(9, c);
    chk("rst_byte_reached", c, 9);
    chk("rst_byte_value", spi_data, 8'hF0);
    reset = 1;
    @(negedge clk);
    chk("mid_rst_start", spi_start, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_words", words_sent, 0);
    chk("mid_rst_ready", word_ready, 0);
    reset = 0;
    @(negedge clk);
    chk("mid_rst_ready_after", word_ready, 1);
    repeat (30) @(negedge clk);
    chk("mid_rst_no_start", q.size(), 9);

    load(32'h1000_0000);
    q.delete();
    send(32'h1234_5678);
    wait_starts(7, c);
    load(32'h2000_0000);
    wait_idle();
    chk("pl_old_addr", qword(1), 32'h1000_0000);
    chk("pl_data", qword(6), 32'h1234_5678);
    chk("pl_words", words_sent, 1);
    chk("pl_incr_first", cur_addr, 32'h1000_0004);
    @(negedge clk);
    chk("pl_applied", cur_addr, 32'h2000_0000);
    q.delete();
    send(32'h0BAD_CAFE);
    wait_idle();
    chk("pl_nbytes", q.size(), 10);
    chk("pl_new_addr", qword(1), 32'h2000_0000);
    chk("pl_words2", words_sent, 2);
    chk("pl_cur_addr", cur_addr, 32'h2000_0004);

    en2 = 1;
    load(32'h0000_FFFC);
    q2.delete();
    send(32'h1111_1111);
    wait_idle();
    send(32'h2222_2222);
    wait_idle();
    chk("a2_nbytes", q2.size(), 16);
    chk("a2_addr0", {q2[1], q2[2]}, 16'hFFFC);
    chk("a2_addr1_wrap", {q2[9], q2[10]}, 16'h0000);
    chk("a2_op_data1", q2[11], 8'h02);
    chk("a2_data1", {q2[12], q2[13], q2[14], q2[15]}, 32'h2222_2222);
    chk("a2_cur_addr", cur_addr2, 16'h0004);
    chk("a2_words", words_sent2, 2);
    chk("a2_busy", busy2, 0);
    chk("a2_tmo", timeout_err2, 0);
    chk("a2_ready", word_ready2, 1);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
